// File: rtl/hazard_scheduler.sv
// Issue controller: per-register pending-write scoreboard that holds the decoded instruction on RAW/saturation hazards.
// Zero latency from inputs to enables; a held instruction freezes PC and fetch/decode and bubbles register-read.
module hazard_scheduler #(
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int CNT_WIDTH        = 2,
  parameter int WB_BYPASS        = 1,
  parameter int ZERO_REG         = 1,
  parameter int STALL_CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        dec_valid,
  input  logic [REG_ADDRESS_SIZE-1:0] dec_r1,
  input  logic [REG_ADDRESS_SIZE-1:0] dec_r2,
  input  logic                        dec_ie,
  input  logic [REG_ADDRESS_SIZE-1:0] dec_rd,
  input  logic                        dec_we,
  input  logic                        wb_we,
  input  logic [REG_ADDRESS_SIZE-1:0] wb_rd,
  output logic                        pc_en,
  output logic                        fd_en,
  output logic                        issue,
  output logic                        bubble,
  output logic [STALL_CNT_WIDTH-1:0]  stall_count
);

  localparam int NREG = 2**REG_ADDRESS_SIZE;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0]       pend_q [NREG];
  logic [CNT_WIDTH-1:0]       pend_d [NREG];
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
  logic r1_busy, r2_busy, sat_hazard, hazard, sb_inc, sb_dec;

  // A source whose only pending write is retiring this cycle is readable when the regfile writes first.
  assign r1_busy = (pend_q[dec_r1] != '0)
                && !(WB_BYPASS != 0 && wb_we && wb_rd == dec_r1 && pend_q[dec_r1] == CNT_ONE)
                && !(ZERO_REG != 0 && dec_r1 == '0);
  assign r2_busy = (pend_q[dec_r2] != '0)
                && !(WB_BYPASS != 0 && wb_we && wb_rd == dec_r2 && pend_q[dec_r2] == CNT_ONE)
                && !(ZERO_REG != 0 && dec_r2 == '0);
  assign sat_hazard = dec_we && (pend_q[dec_rd] == CNT_MAX) && !(wb_we && wb_rd == dec_rd);
  assign hazard     = dec_valid && (r1_busy || (!dec_ie && r2_busy) || sat_hazard);

  always_comb begin
    pc_en  = 1'b1;
    fd_en  = 1'b1;
    issue  = 1'b0;
    bubble = 1'b1;
    if (!reset) begin
      if (hazard) begin
        pc_en = 1'b0;
        fd_en = 1'b0;
      end else begin
        issue  = dec_valid;
        bubble = !dec_valid;
      end
    end
  end

  assign sb_inc = issue && dec_we && !(ZERO_REG != 0 && dec_rd == '0);
  assign sb_dec = wb_we && !(ZERO_REG != 0 && wb_rd == '0);

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pend_d[r] = pend_q[r];
      if (sb_inc && dec_rd == REG_ADDRESS_SIZE'(r) && !(sb_dec && wb_rd == REG_ADDRESS_SIZE'(r))) begin
        pend_d[r] = pend_q[r] + CNT_ONE;
      end else if (sb_dec && wb_rd == REG_ADDRESS_SIZE'(r) && !(sb_inc && dec_rd == REG_ADDRESS_SIZE'(r))
                   && pend_q[r] != '0) begin
        pend_d[r] = pend_q[r] - CNT_ONE;
      end
    end
    stall_d = stall_q;
    if (hazard && stall_q != '1) begin
      stall_d = stall_q + STALL_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        pend_q[r] <= '0;
      end
      stall_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        pend_q[r] <= pend_d[r];
      end
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: default instance plus a WB_BYPASS=0 instance with its own stimulus.
module tb_hazard_scheduler;

  logic clk;
  logic reset;
  logic       valid, ie, we, wbwe;
  logic [4:0] r1, r2, rd, wbrd;
  logic       pc_en, fd_en, issue, bubble;
  logic [15:0] stall_count;
  logic       n_valid, n_ie, n_we, n_wbwe;
  logic [4:0] n_r1, n_r2, n_rd, n_wbrd;
  logic       n_pc_en, n_fd_en, n_issue, n_bubble;
  logic [15:0] n_stall_count;

  int checks;
  int errors;

  hazard_scheduler dut (
    .clk(clk), .reset(reset), .dec_valid(valid), .dec_r1(r1), .dec_r2(r2), .dec_ie(ie),
    .dec_rd(rd), .dec_we(we), .wb_we(wbwe), .wb_rd(wbrd), .pc_en(pc_en), .fd_en(fd_en),
    .issue(issue), .bubble(bubble), .stall_count(stall_count)
  );

  hazard_scheduler #(.WB_BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .dec_valid(n_valid), .dec_r1(n_r1), .dec_r2(n_r2), .dec_ie(n_ie),
    .dec_rd(n_rd), .dec_we(n_we), .wb_we(n_wbwe), .wb_rd(n_wbrd), .pc_en(n_pc_en), .fd_en(n_fd_en),
    .issue(n_issue), .bubble(n_bubble), .stall_count(n_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic drv(input logic v, input logic [4:0] a, input logic [4:0] b, input logic imm,
                     input logic [4:0] d, input logic w, input logic ww, input logic [4:0] wr);
    valid = v; r1 = a; r2 = b; ie = imm; rd = d; we = w; wbwe = ww; wbrd = wr;
  endtask

  task automatic drv_nb(input logic v, input logic [4:0] a, input logic [4:0] b, input logic imm,
                        input logic [4:0] d, input logic w, input logic ww, input logic [4:0] wr);
    n_valid = v; n_r1 = a; n_r2 = b; n_ie = imm; n_rd = d; n_we = w; n_wbwe = ww; n_wbrd = wr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    drv_nb(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    drv(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0);
    reset = 1'b1;
    #2;
    checks++;
    if ({pc_en, fd_en, issue, bubble} !== 4'b1101) begin
      errors++; $display("FAIL reset_outputs: got %b want 1101", {pc_en, fd_en, issue, bubble});
    end
    tick();
    checks++;
    if (stall_count !== 16'd0 || dut.pend_q[3] !== 2'd0) begin
      errors++; $display("FAIL reset_state: stall %0d pend3 %0d want 0 0", stall_count, dut.pend_q[3]);
    end
    reset = 1'b0;
    drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic test_no_dependency;
    do_reset();
    drv(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0);
    #2;
    checks++;
    if ({pc_en, fd_en, issue, bubble} !== 4'b1110) begin
      errors++; $display("FAIL nodep_c0: got %b want 1110", {pc_en, fd_en, issue, bubble});
    end
    tick();
    // immediate form: r2 field names r3 (now pending) but must be ignored
    drv(1'b1, 5'd5, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0);
    #2;
    checks++;
    if ({pc_en, fd_en, issue, bubble} !== 4'b1110) begin
      errors++; $display("FAIL nodep_c1_imm: got %b want 1110", {pc_en, fd_en, issue, bubble});
    end
    tick();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    #2;
    checks++;
    if ({pc_en, fd_en, issue, bubble} !== 4'b1101 || dut.pend_q[3] !== 2'd1 || dut.pend_q[4] !== 2'd1) begin
      errors++; $display("FAIL nodep_idle: out %b pend3 %0d pend4 %0d want 1101 1 1",
                         {pc_en, fd_en, issue, bubble}, dut.pend_q[3], dut.pend_q[4]);
    end
    tick();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3);
    tick();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4);
    #2;
    checks++;
    if (dut.pend_q[3] !== 2'd0 || stall_count !== 16'd0) begin
      errors++; $display("FAIL nodep_retire: pend3 %0d stall %0d want 0 0", dut.pend_q[3], stall_count);
    end
    tick();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic test_raw_bypass;
    logic [3:0] exp_out [1:3];
    exp_out[1] = 4'b0001; exp_out[2] = 4'b0001; exp_out[3] = 4'b1110;
    do_reset();
    drv(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      drv(1'b1, 5'd3, 5'd3, 1'b0, 5'd6, 1'b1, (c == 3), 5'd3);
      #2;
      checks++;
      if ({pc_en, fd_en, issue, bubble} !== exp_out[c]) begin
        errors++; $display("FAIL raw_bypass_c%0d: got %b want %b", c, {pc_en, fd_en, issue, bubble}, exp_out[c]);
      end
      tick();
    end
    drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    #2;
    checks++;
    if (stall_count !== 16'd2 || dut.pend_q[3] !== 2'd0 || dut.pend_q[6] !== 2'd1) begin
      errors++; $display("FAIL raw_bypass_end: stall %0d pend3 %0d pend6 %0d want 2 0 1",
                         stall_count, dut.pend_q[3], dut.pend_q[6]);
    end
  endtask

  task automatic test_raw_no_bypass;
    logic [3:0] exp_out [1:4];
    exp_out[1] = 4'b0001; exp_out[2] = 4'b0001; exp_out[3] = 4'b0001; exp_out[4] = 4'b1110;
    do_reset();
    drv_nb(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0);
    tick();
    for (int c = 1; c <= 4; c++) begin
      drv_nb(1'b1, 5'd3, 5'd3, 1'b0, 5'd6, 1'b1, (c == 3), 5'd3);
      #2;
      checks++;
      if ({n_pc_en, n_fd_en, n_issue, n_bubble} !== exp_out[c]) begin
        errors++; $display("FAIL raw_nobypass_c%0d: got %b want %b", c,
                           {n_pc_en, n_fd_en, n_issue, n_bubble}, exp_out[c]);
      end
      tick();
    end
    drv_nb(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    #2;
    checks++;
    if (n_stall_count !== 16'd3) begin
      errors++; $display("FAIL raw_nobypass_count: got %0d want 3", n_stall_count);
    end
  endtask

  task automatic test_zero_reg;
    do_reset();
    drv(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0);
    tick();
    drv(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd9);
    #2;
    checks++;
    if ({pc_en, fd_en, issue, bubble} !== 4'b1110 || dut.pend_q[0] !== 2'd0) begin
      errors++; $display("FAIL zero_reg: out %b pend0 %0d want 1110 0", {pc_en, fd_en, issue, bubble}, dut.pend_q[0]);
    end
    tick();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    #2;
    checks++;
    if (dut.pend_q[9] !== 2'd0 || dut.pend_q[5] !== 2'd1 || stall_count !== 16'd0) begin
      errors++; $display("FAIL underflow: pend9 %0d pend5 %0d stall %0d want 0 1 0",
                         dut.pend_q[9], dut.pend_q[5], stall_count);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drv(1'b1, 5'd1, 5'd2, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0);
      tick();
    end
    #2;
    checks++;
    if (dut.pend_q[7] !== 2'd3) begin
      errors++; $display("FAIL sat_fill: pend7 %0d want 3", dut.pend_q[7]);
    end
    for (int c = 0; c < 2; c++) begin
      drv(1'b1, 5'd1, 5'd2, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0);
      #2;
      checks++;
      if ({pc_en, fd_en, issue, bubble} !== 4'b0001) begin
        errors++; $display("FAIL sat_stall_%0d: got %b want 0001", c, {pc_en, fd_en, issue, bubble});
      end
      tick();
    end
    drv(1'b1, 5'd1, 5'd2, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7);
    #2;
    checks++;
    if ({pc_en, fd_en, issue, bubble} !== 4'b1110) begin
      errors++; $display("FAIL sat_release: got %b want 1110", {pc_en, fd_en, issue, bubble});
    end
    tick();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    #2;
    checks++;
    if (dut.pend_q[7] !== 2'd3 || stall_count !== 16'd2) begin
      errors++; $display("FAIL sat_same_cycle: pend7 %0d stall %0d want 3 2", dut.pend_q[7], stall_count);
    end
  endtask

  task automatic test_reset_mid_stall;
    do_reset();
    drv(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0);
    tick();
    drv(1'b1, 5'd3, 5'd3, 1'b0, 5'd6, 1'b1, 1'b0, 5'd0);
    tick();
    #2;
    checks++;
    if ({pc_en, fd_en, issue, bubble} !== 4'b0001 || stall_count !== 16'd1) begin
      errors++; $display("FAIL midstall_pre: out %b stall %0d want 0001 1", {pc_en, fd_en, issue, bubble}, stall_count);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (dut.pend_q[3] !== 2'd0 || stall_count !== 16'd0 || {pc_en, fd_en, issue, bubble} !== 4'b1101) begin
      errors++; $display("FAIL midstall_reset: pend3 %0d stall %0d out %b want 0 0 1101",
                         dut.pend_q[3], stall_count, {pc_en, fd_en, issue, bubble});
    end
    tick();
    reset = 1'b0;
    #2;
    checks++;
    if ({pc_en, fd_en, issue, bubble} !== 4'b1110) begin
      errors++; $display("FAIL midstall_after: got %b want 1110", {pc_en, fd_en, issue, bubble});
    end
    tick();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    #2;
    checks++;
    if (stall_count !== 16'd0) begin
      errors++; $display("FAIL midstall_count: got %0d want 0", stall_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    drv_nb(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    tick();
    test_reset();
    test_no_dependency();
    test_raw_bypass();
    test_raw_no_bypass();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
